// File: rtl/sd_spi_responder.sv
// SPI-mode SD card responder: receives 48-bit command frames on mosi, answers with R1 on miso,
// and for CMD17 returns a start token, a word from the backing store and its CRC16.
module sd_spi_responder #(
  parameter int NCR        = 2,
  parameter int NAC        = 4,
  parameter int DATA_BITS  = 32,
  parameter int INIT_POLLS = 3,
  parameter int CRC_CHECK  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cs,
  input  logic                 mosi,
  output logic                 miso,
  output logic                 rd_req,
  output logic [31:0]          rd_addr,
  input  logic [DATA_BITS-1:0] rd_data,
  output logic                 cmd_strobe,
  output logic [5:0]           last_cmd,
  output logic                 initialized,
  output logic                 busy
);

  typedef enum logic [3:0] {
    IDLE, CMD_SHIFT, CHECK, NCR_WAIT, SEND_R1, NAC_WAIT, SEND_TOKEN, SEND_DATA, SEND_CRC
  } state_t;

  localparam logic [15:0] NCR_LAST = 16'(NCR - 1);
  localparam logic [15:0] NAC_LAST = 16'(NAC - 1);
  localparam logic [15:0] DB_LEN   = 16'(DATA_BITS);
  localparam logic [7:0]  POLLS    = 8'(INIT_POLLS);
  localparam logic [7:0]  TOKEN    = 8'hFE;

  state_t               state;
  logic [47:0]          frame;
  logic [15:0]          cnt;
  logic [7:0]           r1;
  logic [7:0]           poll_cnt;
  logic                 app_cmd;
  logic                 cmd17_go;
  logic                 rd_pend;
  logic [DATA_BITS-1:0] data_q;
  logic [DATA_BITS-1:0] dsh;
  logic [15:0]          crc;

  function automatic logic [6:0] crc7(input logic [39:0] d);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int unsigned i = 0; i < 40; i++) begin
      fb = c[6] ^ d[39-i];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic b);
    logic fb;
    fb = c[15] ^ b;
    return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  logic [5:0] idx;
  logic       crc_err, supported, illegal, accept;
  logic       init_n, app_n;
  logic [7:0] poll_n;
  logic [7:0] r1_n;

  // Command decode and its effect on the card state, evaluated on the frame held in CHECK.
  always_comb begin
    idx       = frame[45:40];
    crc_err   = (CRC_CHECK != 0) && (frame[7:1] != crc7(frame[47:8]));
    supported = 1'b0;
    case (idx)
      6'd0, 6'd55: supported = 1'b1;
      6'd41:       supported = app_cmd;
      6'd17:       supported = initialized;
      default:     supported = 1'b0;
    endcase
    illegal = frame[47] | ~frame[46] | ~frame[0] | ~supported;
    accept  = ~crc_err & ~illegal;
    init_n  = initialized;
    poll_n  = poll_cnt;
    app_n   = app_cmd;
    if (accept) begin
      app_n = (idx == 6'd55);
      if (idx == 6'd0) begin
        init_n = 1'b0;
        poll_n = '0;
      end
      if (idx == 6'd41) begin
        if (poll_cnt < POLLS) poll_n = poll_cnt + 8'd1;
        if (poll_n >= POLLS) init_n = 1'b1;
      end
    end
    r1_n = {4'b0000, crc_err, illegal, 1'b0, ~init_n};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      miso        <= 1'b1;
      rd_req      <= 1'b0;
      rd_addr     <= '0;
      cmd_strobe  <= 1'b0;
      last_cmd    <= '0;
      initialized <= 1'b0;
      busy        <= 1'b0;
      frame       <= '0;
      cnt         <= '0;
      r1          <= '0;
      poll_cnt    <= '0;
      app_cmd     <= 1'b0;
      cmd17_go    <= 1'b0;
      rd_pend     <= 1'b0;
      data_q      <= '0;
      dsh         <= '0;
      crc         <= '0;
    end else begin
      cmd_strobe <= 1'b0;
      rd_req     <= 1'b0;
      rd_pend    <= rd_req;
      if (rd_pend) data_q <= rd_data;

      if (state != IDLE && cs) begin
        state <= IDLE;
        miso  <= 1'b1;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: if (!cs && !mosi) begin
            frame <= {frame[46:0], mosi};
            cnt   <= 16'd1;
            busy  <= 1'b1;
            state <= CMD_SHIFT;
          end
          CMD_SHIFT: begin
            frame <= {frame[46:0], mosi};
            cnt   <= cnt + 16'd1;
            if (cnt == 16'd47) state <= CHECK;
          end
          CHECK: begin
            cmd_strobe  <= 1'b1;
            last_cmd    <= idx;
            r1          <= r1_n;
            initialized <= init_n;
            poll_cnt    <= poll_n;
            app_cmd     <= app_n;
            cmd17_go    <= accept && (idx == 6'd17);
            if (accept && (idx == 6'd17)) begin
              rd_req  <= 1'b1;
              rd_addr <= frame[39:8];
            end
            cnt   <= '0;
            state <= NCR_WAIT;
          end
          // Each phase drives the first bit of the next phase on its last edge, so no gap appears.
          NCR_WAIT: if (cnt == NCR_LAST) begin
            miso  <= r1[7];
            cnt   <= 16'd1;
            state <= SEND_R1;
          end else cnt <= cnt + 16'd1;
          SEND_R1: if (cnt == 16'd8) begin
            miso <= 1'b1;
            cnt  <= '0;
            if (cmd17_go) state <= NAC_WAIT;
            else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            miso <= r1[3'd7 - cnt[2:0]];
            cnt  <= cnt + 16'd1;
          end
          NAC_WAIT: if (cnt == NAC_LAST) begin
            miso  <= TOKEN[7];
            cnt   <= 16'd1;
            state <= SEND_TOKEN;
          end else cnt <= cnt + 16'd1;
          SEND_TOKEN: if (cnt == 16'd8) begin
            miso  <= data_q[DATA_BITS-1];
            crc   <= crc16_step('0, data_q[DATA_BITS-1]);
            dsh   <= data_q << 1;
            cnt   <= 16'd1;
            state <= SEND_DATA;
          end else begin
            miso <= TOKEN[3'd7 - cnt[2:0]];
            cnt  <= cnt + 16'd1;
          end
          SEND_DATA: if (cnt == DB_LEN) begin
            miso  <= crc[15];
            crc   <= crc << 1;
            cnt   <= 16'd1;
            state <= SEND_CRC;
          end else begin
            miso <= dsh[DATA_BITS-1];
            crc  <= crc16_step(crc, dsh[DATA_BITS-1]);
            dsh  <= dsh << 1;
            cnt  <= cnt + 16'd1;
          end
          SEND_CRC: if (cnt == 16'd16) begin
            miso  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            miso <= crc[15];
            crc  <= crc << 1;
            cnt  <= cnt + 16'd1;
          end
          default: begin
            state <= IDLE;
            miso  <= 1'b1;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sd_spi_responder.sv
// Randomized scoreboard bench for sd_spi_responder against a frame-level card model.
module tb_sd_spi_responder;
  localparam int NCR   = 2;
  localparam int NAC   = 4;
  localparam int DB    = 32;
  localparam int POLLS = 3;

  logic          clk = 1'b0;
  logic          reset, cs, mosi;
  logic          miso, rd_req, cmd_strobe, initialized, busy;
  logic [31:0]   rd_addr;
  logic [DB-1:0] rd_data;
  logic [5:0]    last_cmd;

  sd_spi_responder #(
    .NCR(NCR), .NAC(NAC), .DATA_BITS(DB), .INIT_POLLS(POLLS), .CRC_CHECK(1)
  ) dut (
    .clk(clk), .reset(reset), .cs(cs), .mosi(mosi), .miso(miso),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data),
    .cmd_strobe(cmd_strobe), .last_cmd(last_cmd),
    .initialized(initialized), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [5:0]    cmd;
    logic [7:0]    r1;
    bit            has_data;
    logic [31:0]   addr;
    logic [DB-1:0] data;
    logic [15:0]   crc;
  } exp_t;

  exp_t exp_q[$];

  int m_init = 0;
  int m_poll = 0;
  bit m_app  = 1'b0;

  // CRCs as polynomial long division of the message padded with zeros.
  function automatic logic [6:0] ref_crc7(input logic [39:0] msg);
    logic [46:0] v;
    logic [46:0] poly;
    v    = {msg, 7'b0};
    poly = 47'h89;
    for (int i = 46; i >= 7; i--)
      if (v[i]) v = v ^ (poly << (i - 7));
    return v[6:0];
  endfunction

  function automatic logic [15:0] ref_crc16(input logic [DB-1:0] d);
    logic [DB+15:0] v;
    logic [DB+15:0] poly;
    v    = {d, 16'b0};
    poly = (DB+16)'(17'h11021);
    for (int i = DB + 15; i >= 16; i--)
      if (v[i]) v = v ^ (poly << (i - 16));
    return v[15:0];
  endfunction

  function automatic logic [DB-1:0] mem_word(input logic [31:0] a);
    if (a == 32'h200) return 32'hDEADBEEF;
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  always @(posedge clk) rd_data <= rd_req ? mem_word(rd_addr) : DB'($urandom);

  function automatic logic [47:0] make_frame(input logic [5:0] cmd, input logic [31:0] arg,
                                             input bit crc_ok, input bit stop_ok, input bit tx_ok);
    logic [39:0] hdr;
    logic [6:0]  c;
    hdr = {1'b0, tx_ok, cmd, arg};
    c   = ref_crc7(hdr);
    if (!crc_ok) c = c ^ 7'h01;
    return {hdr, c, stop_ok};
  endfunction

  task automatic model(input logic [47:0] f, output exp_t e);
    logic [5:0] cmd;
    bit crcbad, sup, illegal;
    cmd     = f[45:40];
    crcbad  = (f[7:1] != ref_crc7(f[47:8]));
    sup     = (cmd == 0) || (cmd == 55) || (cmd == 41 && m_app) || (cmd == 17 && m_init != 0);
    illegal = !f[46] || !f[0] || !sup;
    e.cmd = cmd; e.has_data = 1'b0; e.addr = '0; e.data = '0; e.crc = '0;
    if (!crcbad && !illegal) begin
      if (cmd == 0) begin m_init = 0; m_poll = 0; end
      if (cmd == 41) begin
        m_poll = (m_poll + 1 > POLLS) ? POLLS : m_poll + 1;
        if (m_poll == POLLS) m_init = 1;
      end
      if (cmd == 17) begin
        e.has_data = 1'b1;
        e.addr     = f[39:8];
        e.data     = mem_word(f[39:8]);
        e.crc      = ref_crc16(e.data);
      end
      m_app = (cmd == 55);
    end
    e.r1 = {4'b0, crcbad, illegal, 1'b0, (m_init == 0)};
  endtask

  task automatic send(input logic [47:0] f, input int nbits);
    for (int i = 47; i > 47 - nbits; i--) begin
      @(negedge clk);
      mosi = f[i];
    end
    @(negedge clk);
    mosi = 1'b1;
  endtask

  task automatic txn(input logic [47:0] f);
    exp_t e;
    model(f, e);
    exp_q.push_back(e);
    send(f, 48);
    repeat (90) @(negedge clk);
    check("initialized", 64'(initialized), 64'(m_init));
  endtask

  task automatic collect(input int n, output logic [63:0] v, output bit ok);
    v  = '0;
    ok = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (reset) begin
        ok = 1'b0;
        return;
      end
      v = {v[62:0], miso};
    end
  endtask

  function automatic logic [63:0] ones(input int n);
    return (64'd1 << n) - 64'd1;
  endfunction

  // Monitor: every cmd_strobe consumes one expectation and follows the serial response bit by bit.
  initial begin
    exp_t        e;
    logic [63:0] v;
    bit          ok;
    forever begin
      @(negedge clk);
      if (!reset && cmd_strobe === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL strobe: unexpected cmd_strobe with last_cmd=%0d, expected none", last_cmd);
        end else begin
          e = exp_q.pop_front();
          check("last_cmd", 64'(last_cmd), 64'(e.cmd));
          check("rd_req", 64'(rd_req), 64'(e.has_data));
          if (e.has_data) check("rd_addr", 64'(rd_addr), 64'(e.addr));
          check("busy_active", 64'(busy), 64'd1);
          check("ncr_first_idle", 64'(miso), 64'd1);
          collect(NCR - 1, v, ok);
          if (ok) check("ncr_idle", v, ones(NCR - 1));
          if (ok) collect(8, v, ok);
          if (ok) check("r1", v, 64'(e.r1));
          if (ok && e.has_data) begin
            collect(NAC, v, ok);
            if (ok) check("nac_idle", v, ones(NAC));
            if (ok) collect(8, v, ok);
            if (ok) check("token", v, 64'hFE);
            if (ok) collect(DB, v, ok);
            if (ok) check("data", v, 64'(e.data));
            if (ok) collect(16, v, ok);
            if (ok) check("crc16", v, 64'(e.crc));
          end
          if (ok) collect(1, v, ok);
          if (ok) begin
            check("end_idle", v, 64'd1);
            check("busy_end", 64'(busy), 64'd0);
          end
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL timeout: simulation still running, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [47:0] f;
    exp_t        e;
    int          r;
    logic [5:0]  cmd;

    reset = 1'b1; cs = 1'b1; mosi = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_miso", 64'(miso), 64'd1);
    check("rst_rd_req", 64'(rd_req), 64'd0);
    check("rst_rd_addr", 64'(rd_addr), 64'd0);
    check("rst_strobe", 64'(cmd_strobe), 64'd0);
    check("rst_last_cmd", 64'(last_cmd), 64'd0);
    check("rst_init", 64'(initialized), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    cs = 1'b0;
    repeat (2) @(negedge clk);

    // Directed: CMD0, CMD0 with bad CRC, CMD17 before init, init sequence, CMD17 after init.
    txn(make_frame(6'd0, 32'h0, 1, 1, 1));
    txn(make_frame(6'd0, 32'h0, 0, 1, 1));
    txn(make_frame(6'd17, 32'h200, 1, 1, 1));
    txn(make_frame(6'd0, 32'h0, 1, 1, 1));
    for (int k = 0; k < 3; k++) begin
      txn(make_frame(6'd55, 32'h0, 1, 1, 1));
      txn(make_frame(6'd41, 32'h40000000, 1, 1, 1));
    end
    txn(make_frame(6'd17, 32'h200, 1, 1, 1));

    // Aborted frame must produce nothing; the following CMD0 answers normally.
    send(make_frame(6'd0, 32'h0, 1, 1, 1), 20);
    cs = 1'b1;
    repeat (3) @(negedge clk);
    cs = 1'b0;
    repeat (3) @(negedge clk);
    txn(make_frame(6'd0, 32'h0, 1, 1, 1));

    for (int k = 0; k < 60; k++) begin
      r = $urandom_range(0, 9);
      if (r <= 2)      cmd = 6'd55;
      else if (r <= 4) cmd = 6'd41;
      else if (r <= 6) cmd = 6'd17;
      else if (r == 7) cmd = 6'd0;
      else             cmd = 6'($urandom_range(0, 63));
      txn(make_frame(cmd, $urandom, $urandom_range(0, 7) != 0,
                     $urandom_range(0, 15) != 0, $urandom_range(0, 15) != 0));
    end

    // Reset in the middle of a data packet.
    txn(make_frame(6'd0, 32'h0, 1, 1, 1));
    for (int k = 0; k < 3; k++) begin
      txn(make_frame(6'd55, 32'h0, 1, 1, 1));
      txn(make_frame(6'd41, 32'h0, 1, 1, 1));
    end
    f = make_frame(6'd17, 32'h1234, 1, 1, 1);
    model(f, e);
    exp_q.push_back(e);
    send(f, 48);
    repeat (28) @(negedge clk);
    check("busy_in_data", 64'(busy), 64'd1);
    #2 reset = 1'b1;
    #1;
    check("midrst_miso", 64'(miso), 64'd1);
    check("midrst_init", 64'(initialized), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    m_init = 0; m_poll = 0; m_app = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    txn(make_frame(6'd0, 32'h0, 1, 1, 1));

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
